// File: rtl/hit_flash_if.sv
// Bundles the per-pixel/per-frame inputs and the status outputs of the hit/flash controller.
// The stimulus side (renderer/game logic) uses master; the controller uses slave.
// Clock and reset stay outside the bundle as plain ports.
interface hit_flash_if;
  logic       frame_tick;
  logic       blank;
  logic       player_render;
  logic       object_trigger_signal;
  logic       object_colider_signal;
  logic       restart;
  logic       is_trigger_player;
  logic       hit_pulse;
  logic [7:0] hp;
  logic       invuln;
  logic       game_over;
  logic       blocked;

  modport master (
    output frame_tick, blank, player_render, object_trigger_signal,
           object_colider_signal, restart,
    input  is_trigger_player, hit_pulse, hp, invuln, game_over, blocked
  );

  modport slave (
    input  frame_tick, blank, player_render, object_trigger_signal,
           object_colider_signal, restart,
    output is_trigger_player, hit_pulse, hp, invuln, game_over, blocked
  );
endinterface

// File: rtl/hit_flash_controller.sv
// Player hit-point / invulnerability-flash controller driven by per-pixel overlap and frame ticks.
// Latency: overlaps latch within the frame; state, hp, hit_pulse and tint update 1 clock after frame_tick.
// Backpressure: none; inputs are sampled every cycle and outputs are level/pulse status.
module hit_flash_controller #(
  parameter int HP_MAX        = 92,
  parameter int DAMAGE        = 1,
  parameter int INVULN_FRAMES = 30,
  parameter int FLASH_PERIOD  = 4
) (
  input  logic     clk,
  input  logic     reset,
  hit_flash_if.slave bus
);

  typedef enum logic [1:0] {IDLE, INVULN, DEAD} state_t;

  localparam logic [7:0] HP_INIT    = 8'(HP_MAX);
  localparam logic [7:0] DMG        = 8'(DAMAGE);
  localparam logic [7:0] INV_LEN    = 8'(INVULN_FRAMES);
  localparam logic [3:0] FLASH_LAST = 4'(FLASH_PERIOD - 1);

  state_t     state, state_nxt;
  logic [7:0] hp_q, hp_nxt;
  logic [7:0] cnt_q, cnt_nxt;
  logic [3:0] fcnt_q, fcnt_nxt;
  logic       phase_q, phase_nxt;
  logic       hit_q, hit_nxt;
  logic       touch_q, touch_nxt;
  logic       blocked_q, blocked_nxt;
  logic       pulse_q, pulse_nxt;
  logic       tint_q, tint_nxt;
  logic       hit_px, touch_px;

  // Only visible pixels where the player overlaps an object count.
  assign hit_px   = !bus.blank && bus.player_render && bus.object_trigger_signal;
  assign touch_px = !bus.blank && bus.player_render && bus.object_colider_signal;

  // Next-state logic: pending flags, frame-boundary FSM, flash timing and tint.
  always_comb begin
    state_nxt   = state;
    hp_nxt      = hp_q;
    cnt_nxt     = cnt_q;
    fcnt_nxt    = fcnt_q;
    phase_nxt   = phase_q;
    pulse_nxt   = 1'b0;
    // An overlap on the frame_tick cycle belongs to the new frame, so set beats clear.
    hit_nxt     = hit_px   || (hit_q   && !bus.frame_tick);
    touch_nxt   = touch_px || (touch_q && !bus.frame_tick);
    blocked_nxt = bus.frame_tick ? touch_q : blocked_q;

    case (state)
      IDLE: begin
        if (bus.frame_tick && hit_q) begin
          pulse_nxt = 1'b1;
          if (hp_q > DMG) begin
            hp_nxt    = hp_q - DMG;
            state_nxt = INVULN;
            cnt_nxt   = INV_LEN;
            fcnt_nxt  = 4'd0;
            phase_nxt = 1'b1;
          end else begin
            hp_nxt    = 8'd0;
            state_nxt = DEAD;
          end
        end
      end
      INVULN: begin
        // Hits are ignored here; only the frame counters advance.
        if (bus.frame_tick) begin
          if (cnt_q <= 8'd1) begin
            state_nxt = IDLE;
            cnt_nxt   = 8'd0;
            fcnt_nxt  = 4'd0;
            phase_nxt = 1'b0;
          end else begin
            cnt_nxt = cnt_q - 8'd1;
            if (fcnt_q == FLASH_LAST) begin
              fcnt_nxt  = 4'd0;
              phase_nxt = !phase_q;
            end else begin
              fcnt_nxt = fcnt_q + 4'd1;
            end
          end
        end
      end
      DEAD: begin
        // frame_tick is irrelevant here; restart always wins.
        if (bus.restart) begin
          state_nxt = IDLE;
          hp_nxt    = HP_INIT;
          cnt_nxt   = 8'd0;
          fcnt_nxt  = 4'd0;
          phase_nxt = 1'b0;
          hit_nxt   = 1'b0;
          touch_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Tint is computed from the next state so it registers in step with the FSM.
    tint_nxt = (state_nxt == DEAD) || ((state_nxt == INVULN) && phase_nxt);
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      hp_q      <= HP_INIT;
      cnt_q     <= 8'd0;
      fcnt_q    <= 4'd0;
      phase_q   <= 1'b0;
      hit_q     <= 1'b0;
      touch_q   <= 1'b0;
      blocked_q <= 1'b0;
      pulse_q   <= 1'b0;
      tint_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      hp_q      <= hp_nxt;
      cnt_q     <= cnt_nxt;
      fcnt_q    <= fcnt_nxt;
      phase_q   <= phase_nxt;
      hit_q     <= hit_nxt;
      touch_q   <= touch_nxt;
      blocked_q <= blocked_nxt;
      pulse_q   <= pulse_nxt;
      tint_q    <= tint_nxt;
    end
  end

  assign bus.hp                = hp_q;
  assign bus.hit_pulse         = pulse_q;
  assign bus.is_trigger_player = tint_q;
  assign bus.blocked           = blocked_q;
  assign bus.invuln            = (state == INVULN);
  assign bus.game_over         = (state == DEAD);

endmodule

// File: tb/tb_hit_flash_controller.sv
// Directed bench for hit_flash_controller: default build plus a one-hit-kill build.
// Inputs change just after the falling edge; outputs are read at the next falling edge.
// Expected values are hand-computed constants.
module tb_hit_flash_controller;
  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   checks = 0;
  int   failures = 0;

  hit_flash_if ifa();
  hit_flash_if ifb();

  hit_flash_controller dut_a (.clk(clk), .reset(rst_a), .bus(ifa));

  hit_flash_controller #(.HP_MAX(2), .DAMAGE(3), .INVULN_FRAMES(30), .FLASH_PERIOD(4))
    dut_b (.clk(clk), .reset(rst_b), .bus(ifb));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs (frame_tick, blank, player, trigger, collider, restart).
  task automatic step_a(input logic ft, bl, pr, tr, co, rs);
    ifa.frame_tick = ft; ifa.blank = bl; ifa.player_render = pr;
    ifa.object_trigger_signal = tr; ifa.object_colider_signal = co; ifa.restart = rs;
    @(negedge clk);
  endtask

  task automatic step_b(input logic ft, bl, pr, tr, co, rs);
    ifb.frame_tick = ft; ifb.blank = bl; ifb.player_render = pr;
    ifb.object_trigger_signal = tr; ifb.object_colider_signal = co; ifb.restart = rs;
    @(negedge clk);
  endtask

  initial begin
    rst_a = 1'b0;
    rst_b = 1'b0;
    step_b(0, 0, 0, 0, 0, 0);
    step_a(0, 0, 0, 0, 0, 0);
    step_a(0, 0, 0, 0, 0, 0);

    // Reset state
    chk("rst_hp",      ifa.hp, 92);
    chk("rst_invuln",  ifa.invuln, 0);
    chk("rst_over",    ifa.game_over, 0);
    chk("rst_tint",    ifa.is_trigger_player, 0);
    chk("rst_pulse",   ifa.hit_pulse, 0);
    chk("rst_blocked", ifa.blocked, 0);
    chk("rst_b_hp",    ifb.hp, 2);
    rst_a = 1'b1;
    rst_b = 1'b1;

    // Single visible overlap then frame_tick -> one hit
    step_a(0, 0, 1, 1, 0, 0);
    chk("pre_tick_pulse", ifa.hit_pulse, 0);
    step_a(1, 0, 0, 0, 0, 0);
    chk("hit_pulse", ifa.hit_pulse, 1);
    chk("hit_hp",    ifa.hp, 91);
    chk("hit_inv",   ifa.invuln, 1);
    chk("hit_tint",  ifa.is_trigger_player, 1);
    step_a(0, 0, 0, 0, 0, 0);
    chk("pulse_one_cycle", ifa.hit_pulse, 0);

    // Continuous overlap through the whole invulnerability window
    for (int k = 1; k <= 30; k++) begin
      step_a(0, 0, 1, 1, 0, 0);
      step_a(1, 0, 1, 1, 0, 0);
      chk("inv_hp",    ifa.hp, 91);
      chk("inv_pulse", ifa.hit_pulse, 0);
      if (k < 30) begin
        chk("inv_flag", ifa.invuln, 1);
        chk("inv_tint", ifa.is_trigger_player, ((k / 4) % 2 == 0) ? 1 : 0);
      end else begin
        chk("inv_exit_flag", ifa.invuln, 0);
        chk("inv_exit_tint", ifa.is_trigger_player, 0);
      end
    end
    step_a(1, 0, 0, 0, 0, 0);
    chk("rehit_pulse", ifa.hit_pulse, 1);
    chk("rehit_hp",    ifa.hp, 90);

    // 13 ticks -> counter 17, then reset mid-INVULN
    for (int k = 0; k < 13; k++) step_a(1, 0, 0, 0, 0, 0);
    chk("cnt17_inv", ifa.invuln, 1);
    rst_a = 1'b0;
    step_a(0, 0, 1, 1, 1, 0);
    rst_a = 1'b1;
    chk("mid_rst_hp",      ifa.hp, 92);
    chk("mid_rst_inv",     ifa.invuln, 0);
    chk("mid_rst_tint",    ifa.is_trigger_player, 0);
    chk("mid_rst_pulse",   ifa.hit_pulse, 0);
    chk("mid_rst_blocked", ifa.blocked, 0);

    // Overlap only during blank -> nothing
    step_a(0, 1, 1, 1, 0, 0);
    step_a(0, 1, 1, 1, 0, 0);
    step_a(1, 0, 0, 0, 0, 0);
    chk("blank_pulse", ifa.hit_pulse, 0);
    chk("blank_hp",    ifa.hp, 92);
    // Overlap on the tick cycle only -> counts for the next frame
    step_a(1, 0, 1, 1, 0, 0);
    chk("tickov_pulse", ifa.hit_pulse, 0);
    chk("tickov_hp",    ifa.hp, 92);
    step_a(1, 0, 0, 0, 0, 0);
    chk("tickov_next_pulse", ifa.hit_pulse, 1);
    chk("tickov_next_hp",    ifa.hp, 91);
    for (int k = 0; k < 30; k++) step_a(1, 0, 0, 0, 0, 0);
    chk("drain_inv", ifa.invuln, 0);

    // Restart outside DEAD is ignored
    step_a(0, 0, 0, 0, 0, 1);
    chk("restart_idle_hp",   ifa.hp, 91);
    chk("restart_idle_over", ifa.game_over, 0);

    // Collider for one frame
    step_a(0, 0, 1, 0, 1, 0);
    step_a(0, 0, 0, 0, 0, 0);
    chk("blk_before", ifa.blocked, 0);
    step_a(1, 0, 0, 0, 0, 0);
    chk("blk_set", ifa.blocked, 1);
    chk("blk_hp",  ifa.hp, 91);
    step_a(0, 0, 0, 0, 0, 0);
    chk("blk_hold", ifa.blocked, 1);
    step_a(1, 0, 0, 0, 0, 0);
    chk("blk_clr", ifa.blocked, 0);

    // One-hit-kill build: saturation to 0 and DEAD
    step_b(0, 0, 1, 1, 0, 0);
    step_b(1, 0, 0, 0, 0, 0);
    chk("b_pulse", ifb.hit_pulse, 1);
    chk("b_hp0",   ifb.hp, 0);
    chk("b_over",  ifb.game_over, 1);
    chk("b_tint",  ifb.is_trigger_player, 1);
    chk("b_inv",   ifb.invuln, 0);
    step_b(0, 0, 1, 1, 0, 0);
    step_b(1, 0, 0, 0, 0, 0);
    chk("b_dead_pulse", ifb.hit_pulse, 0);
    chk("b_dead_hp",    ifb.hp, 0);
    chk("b_dead_over",  ifb.game_over, 1);
    // Pending hit latched while dead, then restart coincident with frame_tick
    step_b(0, 0, 1, 1, 0, 0);
    step_b(1, 0, 0, 0, 0, 1);
    chk("b_restart_over", ifb.game_over, 0);
    chk("b_restart_hp",   ifb.hp, 2);
    chk("b_restart_tint", ifb.is_trigger_player, 0);
    step_b(1, 0, 0, 0, 0, 0);
    chk("b_pending_cleared", ifb.hit_pulse, 0);
    chk("b_alive_hp",        ifb.hp, 2);
    // Reset overrides DEAD
    step_b(0, 0, 1, 1, 0, 0);
    step_b(1, 0, 0, 0, 0, 0);
    chk("b_dead_again", ifb.game_over, 1);
    rst_b = 1'b0;
    step_b(0, 0, 0, 0, 0, 0);
    rst_b = 1'b1;
    chk("b_rst_over", ifb.game_over, 0);
    chk("b_rst_hp",   ifb.hp, 2);
    chk("b_rst_tint", ifb.is_trigger_player, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hit_flash_controller.md
HIT_FLASH_CONTROLLER -- requirements
Module: hit_flash_controller

Interface
REQ-001 SHALL have parameter HP_MAX, default 92, meaning starting/restart hit points (1..255).
REQ-002 SHALL have parameter DAMAGE, default 1, meaning HP removed per registered hit (1..255).
REQ-003 SHALL have parameter INVULN_FRAMES, default 30, meaning invulnerability length in frames after a hit (1..255).
REQ-004 SHALL have parameter FLASH_PERIOD, default 4, meaning frames per flash half-cycle (1..15).
REQ-005 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-low reset (asserted at 0).
REQ-007 SHALL have port frame_tick  input  1  one-cycle pulse marking frame boundary (start of vertical blank).
REQ-008 SHALL have port blank  input  1  1 = pixel outside visible area.
REQ-009 SHALL have port player_render  input  1  current pixel belongs to player.
REQ-010 SHALL have port object_trigger_signal  input  1  current pixel belongs to a damaging object.
REQ-011 SHALL have port object_colider_signal  input  1  current pixel belongs to a solid object.
REQ-012 SHALL have port restart  input  1  pulse; revives from DEAD.
REQ-013 SHALL have port is_trigger_player  output  1  background tint request to renderer.
REQ-014 SHALL have port hit_pulse  output  1  one-cycle pulse when damage applied.
REQ-015 SHALL have port hp  output  8  current hit points.
REQ-016 SHALL have port invuln  output  1  1 while in INVULN.
REQ-017 SHALL have port game_over  output  1  1 while in DEAD.
REQ-018 SHALL have port blocked  output  1  player touched a solid object during the last completed frame.

Function
REQ-019 SHALL latch hit_pending when blank=0 and player_render=1 and object_trigger_signal=1 in any cycle.
REQ-020 SHALL latch touch_pending when blank=0 and player_render=1 and object_colider_signal=1.
REQ-021 SHALL clear both pending flags on frame_tick; overlap on the frame_tick cycle SHALL set the flag for the new frame (set wins over clear).
REQ-022 SHALL update blocked on each frame_tick to touch_pending as it was before that edge, holding it until the next frame_tick.
REQ-023 SHALL implement states IDLE, INVULN, DEAD; all transitions occur only on frame_tick, except restart and reset.
REQ-024 IDLE + frame_tick + hit_pending: hp <= hp-DAMAGE saturating at 0, hit_pulse=1 for that cycle; result 0 -> DEAD, else -> INVULN with frame counter = INVULN_FRAMES and flash phase = 1.
REQ-025 IDLE + frame_tick without hit_pending: remain IDLE, no change.
REQ-026 INVULN: hit_pending SHALL be ignored (no damage, no hit_pulse); counter decrements on each frame_tick; on the frame_tick where counter is 1, counter -> 0 and state -> IDLE.
REQ-027 INVULN: flash phase SHALL toggle every FLASH_PERIOD frame_ticks, counted from INVULN entry.
REQ-028 is_trigger_player SHALL be 1 in INVULN when flash phase=1, 1 throughout DEAD, 0 in IDLE; registered output.
REQ-029 DEAD: frame_tick ignored; restart=1 -> IDLE, hp=HP_MAX, pending flags cleared, next cycle.
REQ-030 restart outside DEAD SHALL be ignored; restart coincident with frame_tick in DEAD SHALL take restart.
REQ-031 invuln and game_over SHALL be pure decodes of the registered state.
REQ-032 All outputs SHALL be registered except invuln/game_over decodes; hit_pulse latency = 1 clock after the frame_tick edge.

Reset
REQ-033 With reset=0 at a rising edge: state=IDLE, hp=HP_MAX, counter=0, flash phase=0, pending flags=0, blocked=0, hit_pulse=0, is_trigger_player=0.
REQ-034 Reset SHALL override all other inputs, including mid-INVULN and in DEAD.

Verification
REQ-035 IDLE, hp=92; one overlap pixel (blank=0) then frame_tick -> hit_pulse one cycle, hp=91, invuln=1, is_trigger_player=1.
REQ-036 INVULN_FRAMES=30, FLASH_PERIOD=4; 30 frame_ticks with continuous overlap -> hp stays 91, is_trigger_player toggles every 4 frames, state IDLE after 30th tick; next frame overlap -> hp=90.
REQ-037 Overlap only while blank=1 -> no hit_pulse, hp unchanged; overlap on the frame_tick cycle only -> damage at following frame_tick.
REQ-038 HP_MAX=2, DAMAGE=3; one hit -> hp=0, game_over=1, is_trigger_player=1; further hits ignored; restart -> hp=2, IDLE.
REQ-039 Collider overlap for one frame -> blocked=1 after next frame_tick, blocked=0 after the following frame_tick; hp unchanged.
REQ-040 reset=0 during INVULN counter=17 -> next cycle IDLE, hp=HP_MAX, all outputs at reset values.
